ksa_swap: RTL

- Second stage of the RC4 decrypt datapath.
- Runs immediately after the S-array init loop has filled on-chip S memory with S[i]=i. Starts when that loop's finish drives this block's start.
- Performs the RC4 key-scheduling pass: for i=0..255, j = j + S[i] + key[i mod KEY_BYTES], then swaps S[i] and S[j].
- Shares the same single-port 256x8 S RAM (address/data/wren/q) through the top-level mux. Its finish hands off to the PRGA/decrypt stage.

---
 rtl/lab4_pkg.sv | 23 ++
 rtl/ksa_swap.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lab4_pkg.sv
// Shared types and constants for the RC4 key-scheduling stage.
package lab4_pkg;

    // One state per RAM access phase of a single index, plus idle/done.
    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } ksa_state_t;

    // Last index of the S array; the pass ends after this index is swapped.
    localparam logic [7:0] S_LAST = 8'hFF;

    // Clock cycles spent on each index (RD_I through NEXT).
    localparam int unsigned CYCLES_PER_IDX = 7;

endpackage

// File: rtl/ksa_swap.sv
// RC4 key-scheduling pass over a single-port 256x8 S RAM with registered address.
// For each i: read S[i], update j, read S[j], then write both back swapped.
module ksa_swap
    import lab4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    input  logic [7:0]             q,
    output logic                   finish
);

    // Key index counter is at least one bit wide so KEY_BYTES=1 still elaborates.
    localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    ksa_state_t     state_q, state_d;
    logic [7:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [7:0]     si_q, si_d;
    logic [7:0]     sj_q, sj_d;
    logic [KIW-1:0] key_idx_q, key_idx_d;
    logic [7:0]     key_byte;

    // Select the current key byte; byte 0 is the most significant byte of secret_key.
    always_comb begin
        key_byte = '0;
        for (int unsigned k = 0; k < KEY_BYTES; k++) begin
            if (key_idx_q == KIW'(k)) begin
                key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
            end
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        key_idx_d = key_idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RD_I;
            end
            RD_I:  state_d = LAT_I;
            LAT_I: begin
                si_d    = q;
                j_d     = j_q + q + key_byte;
                state_d = RD_J;
            end
            RD_J:  state_d = LAT_J;
            LAT_J: begin
                sj_d    = q;
                state_d = WR_I;
            end
            WR_I:  state_d = WR_J;
            WR_J:  state_d = NEXT;
            NEXT: begin
                if (i_q == S_LAST) begin
                    state_d = DONE;
                end else begin
                    i_d       = i_q + 8'd1;
                    key_idx_d = (key_idx_q == KIW'(KEY_BYTES - 1)) ? '0 : key_idx_q + 1'b1;
                    state_d   = RD_I;
                end
            end
            DONE: begin
                // Wait for upstream to drop start so a fresh pass needs a new request.
                if (!start) begin
                    state_d   = IDLE;
                    i_d       = '0;
                    j_d       = '0;
                    key_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM-side outputs decoded purely from registered state.
    always_comb begin
        address = '0;
        data    = '0;
        wren    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            RD_I, LAT_I: address = i_q;
            RD_J, LAT_J: address = j_q;
            WR_I: begin
                address = i_q;
                data    = sj_q;
                wren    = 1'b1;
            end
            WR_J: begin
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            key_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            key_idx_q <= key_idx_d;
        end
    end

endmodule
